// File: rtl/keypad4x4_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad4x4_scan
//  Description : 4x4 active-low matrix keypad scanner. Drives one column low
//                at a time, synchronises and samples the rows, debounces
//                whole-keypad snapshots, and emits a one-cycle pulse with a
//                4-bit hex code for every newly accepted single-key press.
//                Optional macro KEYPAD_SHIFT_EN turns o_key_data into an
//                8-digit shift register of the most recent key codes;
//                without it o_key_data carries only the latest code.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad4x4_scan #(
    parameter int SCAN_DIV     = 16384,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic        o_key_valid,
    output logic [3:0]  o_key_code,
    output logic        o_key_down,
    output logic [31:0] o_key_data
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Two-state key tracker: waiting for a press, or waiting for release
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             col_last;
    logic             scan_done;

    logic [15:0]      snap_acc;
    logic [15:0]      snap_next;
    logic [15:0]      prev_snap;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             is_stable;

    logic             snap_zero;
    logic             snap_single;
    logic [3:0]       single_code;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic             fire;

    // ------------------------------------------------------------------
    // Row synchroniser: rows idle high (no key) out of reset
    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= i_row;
            row_sync <= row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Column scan timing
    // ------------------------------------------------------------------
    // Rows are sampled on the final cycle of each column period so the
    // synchronised rows reflect the column that is currently driven.
    assign col_last  = (div_cnt == DIV_LAST);
    assign scan_done = col_last && (col_idx == 2'd3);

    // Column period divider, column index and registered column drive
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
            o_col   <= 4'b1110;
        end else if (col_last) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
            o_col   <= {o_col[2:0], o_col[3]};
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Snapshot assembly
    // ------------------------------------------------------------------
    // Accumulated snapshot with the current column's row samples merged
    // in; at scan completion this is the full 16-key picture.
    always_comb begin
        snap_next = snap_acc;
        for (int r = 0; r < 4; r++) begin
            snap_next[{r[1:0], col_idx}] = ~row_sync[r];
        end
    end

    // Capture each column's rows into the snapshot at its sample point
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_acc <= '0;
        end else if (col_last) begin
            snap_acc <= snap_next;
        end
    end

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    // Count identical consecutive scans; saturate so a long stable period
    // yields only one acceptance transition.
    always_comb begin
        cnt_next = CNT_ONE;
        if (snap_next == prev_snap) begin
            if (stable_cnt == CNT_MAX) begin
                cnt_next = CNT_MAX;
            end else begin
                cnt_next = stable_cnt + CNT_ONE;
            end
        end
    end

    assign is_stable = scan_done && (cnt_next == CNT_MAX);

    // Remember the previous full scan and its stability count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_snap  <= '0;
            stable_cnt <= '0;
        end else if (scan_done) begin
            prev_snap  <= snap_next;
            stable_cnt <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Snapshot classification
    // ------------------------------------------------------------------
    assign snap_zero   = (snap_next == 16'h0000);
    assign snap_single = !snap_zero && ((snap_next & (snap_next - 16'd1)) == 16'h0000);

    // Bit index of the pressed key; only meaningful when exactly one is set.
    // Bit index 4*row+col equals the key code {row, col}.
    always_comb begin
        single_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (snap_next[i]) begin
                single_code = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Press/release tracker
    // ------------------------------------------------------------------
    // Next-state logic: only a stable snapshot can move the tracker; a
    // chord enters HELD silently so it must be fully released first.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        if (is_stable) begin
            case (state)
                ST_IDLE: begin
                    if (snap_single) begin
                        fire       = 1'b1;
                        state_next = ST_HELD;
                    end else if (!snap_zero) begin
                        state_next = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (snap_zero) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Tracker state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign o_key_down = (state == ST_HELD);

    // ------------------------------------------------------------------
    // Key outputs
    // ------------------------------------------------------------------
    // Pulse, held key code and display word, all updated on acceptance
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_key_valid <= 1'b0;
            o_key_code  <= 4'h0;
            o_key_data  <= 32'h0000_0000;
        end else begin
            o_key_valid <= fire;
            if (fire) begin
                o_key_code <= single_code;
`ifdef KEYPAD_SHIFT_EN
                // Newest key enters on the rightmost display digit
                o_key_data <= {o_key_data[27:0], single_code};
`else
                o_key_data <= {28'h0000000, single_code};
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad4x4_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad4x4_scan
//  Description : Self-checking bench for keypad4x4_scan. A keypad matrix
//                model drives the rows from a pressed-key mask; a per-scan
//                behavioural model predicts every output each cycle, and
//                directed scenarios pin key timings with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad4x4_scan;

    localparam int S = 8;
    localparam int D = 3;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        valid;
    logic [3:0]  code;
    logic        down;
    logic [31:0] data;
    logic [15:0] keys = 16'h0000;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    // Physical keypad: row r pulled low when a pressed key joins it to the driven column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && keys[4*r+c]) row[r] = 1'b0;
    end

    keypad4x4_scan #(.SCAN_DIV(S), .DEBOUNCE_CNT(D)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_row       (row),
        .o_col       (col),
        .o_key_valid (valid),
        .o_key_code  (code),
        .o_key_down  (down),
        .o_key_data  (data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: edges since reset, per-scan snapshot rules
    // ------------------------------------------------------------------
    int          n;
    logic [15:0] h1, h2, acc, prev, smp;
    int          cnt, ones, idx, mc;
    bit          held, m_valid;
    logic [3:0]  m_code;
    logic [31:0] m_data;

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                n = 0; h1 = 0; h2 = 0; acc = 0; prev = 0; cnt = 0;
                held = 0; m_valid = 0; m_code = 0; m_data = 0;
            end else begin
                // rows seen by the sampler were launched two edges earlier
                smp = h2; h2 = h1; h1 = keys;
                m_valid = 0;
                if (n % S == S - 1) begin
                    mc = (n / S) % 4;
                    for (int r = 0; r < 4; r++) acc[4*r+mc] = smp[4*r+mc];
                    if (mc == 3) begin
                        if (acc == prev) cnt = (cnt < D) ? cnt + 1 : D;
                        else cnt = 1;
                        prev = acc;
                        if (cnt == D) begin
                            ones = $countones(acc);
                            if (!held && ones == 1) begin
                                idx = 0;
                                for (int i = 0; i < 16; i++) if (acc[i]) idx = i;
                                m_valid = 1;
                                m_code  = 4'(idx);
`ifdef KEYPAD_SHIFT_EN
                                m_data  = {m_data[27:0], m_code};
`else
                                m_data  = {28'h0, m_code};
`endif
                                held = 1;
                            end else if (ones == 0) begin
                                held = 0;
                            end else begin
                                held = 1;
                            end
                        end
                    end
                end
                n++;
            end
        end
    end

    // Compare every cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("col",   {28'h0, col},   {28'h0, 4'hF ^ (4'b0001 << ((n / S) % 4))});
            chk("valid", {31'h0, valid}, {31'h0, m_valid});
            chk("code",  {28'h0, code},  {28'h0, m_code});
            chk("down",  {31'h0, down},  {31'h0, held});
            chk("data",  data,           m_data);
            if (valid === 1'b1) pulses++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_n(input int t);
        while (n < t) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] k);
        @(negedge clk);
        rstn = 1'b0;
        keys = k;
        tick(3);
        rstn = 1'b1;
    endtask

    task automatic wait_pulse(input int limit, output int at, output bit seen);
        seen = 0;
        at   = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #3;
            if (valid === 1'b1) begin
                seen = 1;
                at   = n;
                break;
            end
        end
    endtask

    logic [3:0] col_seq [5];
    int  base, at, key, key2, sel;
    bit  seen;

    initial begin
        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // Reset values
        keys = 16'h0;
        rstn = 1'b0;
        tick(3);
        #3;
        chk("rst_col",   {28'h0, col},   32'h0000_000E);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_code",  {28'h0, code},  32'h0);
        chk("rst_down",  {31'h0, down},  32'h0);
        chk("rst_data",  data,           32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Column stepping, 8 cycles per column
        for (int k = 0; k < 5; k++) begin
            wait_n(4 + 8 * k);
            #3;
            chk("col_step", {28'h0, col}, {28'h0, col_seq[k]});
        end

        // Single press: row 2 / col 1 held from release of reset
        do_reset(16'h0200);
        base = pulses;
        wait_pulse(200, at, seen);
        chk("press_seen",    {31'h0, seen}, 32'h1);
        chk("press_latency", at,            32'd96);
        chk("press_code",    {28'h0, code}, 32'h9);
        chk("press_down",    {31'h0, down}, 32'h1);
        tick(64);
        keys = 16'h0;
        tick(160);
        chk("release_down",  {31'h0, down}, 32'h0);
        chk("press_pulses",  pulses - base, 32'd1);

        // Bounce: 20-cycle toggling for 200 cycles starting on an aligned edge
        do_reset(16'h0);
        base = pulses;
        key  = $urandom_range(0, 15);
        wait_n(64);
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? (16'h1 << key) : 16'h0;
            wait_n(64 + 20 * (i + 1));
        end
        chk("bounce_quiet", pulses - base, 32'd0);
        keys = 16'h1 << key;
        wait_pulse(200, at, seen);
        chk("bounce_seen", {31'h0, seen}, 32'h1);
        chk("bounce_code", {28'h0, code}, key);
        tick(160);
        chk("bounce_pulses", pulses - base, 32'd1);
        keys = 16'h0;
        tick(160);

        // Chord: keys 0 and 5, partial release, full release, then key 5
        base = pulses;
        keys = 16'h0021;
        tick(160);
        chk("chord_quiet", pulses - base, 32'd0);
        chk("chord_down",  {31'h0, down}, 32'h1);
        keys = 16'h0020;
        tick(160);
        chk("chord_part_quiet", pulses - base, 32'd0);
        chk("chord_part_down",  {31'h0, down}, 32'h1);
        keys = 16'h0;
        tick(160);
        chk("chord_release", {31'h0, down}, 32'h0);
        keys = 16'h0020;
        tick(160);
        chk("chord_after_pulses", pulses - base, 32'd1);
        chk("chord_after_code",   {28'h0, code}, 32'h5);
        keys = 16'h0;
        tick(160);

        // Display word after keys 1, 2, 3
        do_reset(16'h0);
        base = pulses;
        for (int k = 1; k <= 3; k++) begin
            keys = 16'h1 << k;
            tick(160);
            keys = 16'h0;
            tick(160);
        end
        chk("shift_pulses", pulses - base, 32'd3);
`ifdef KEYPAD_SHIFT_EN
        chk("shift_data", data, 32'h0000_0123);
`else
        chk("shift_data", data, 32'h0000_0003);
`endif

        // Reset after two stable scans of a held key
        key = $urandom_range(0, 15);
        do_reset(16'h1 << key);
        base = pulses;
        wait_n(80);
        chk("middeb_quiet", pulses - base, 32'd0);
        do_reset(16'h1 << key);
        wait_pulse(200, at, seen);
        chk("middeb_seen",    {31'h0, seen}, 32'h1);
        chk("middeb_latency", at,            32'd96);
        chk("middeb_code",    {28'h0, code}, key);
        keys = 16'h0;
        tick(160);

        // Random key activity checked by the model every cycle
        for (int j = 0; j < 40; j++) begin
            sel  = $urandom_range(0, 9);
            key  = $urandom_range(0, 15);
            key2 = $urandom_range(0, 15);
            if (sel < 6)      keys = 16'h1 << key;
            else if (sel < 8) keys = 16'h0;
            else              keys = (16'h1 << key) | (16'h1 << key2);
            tick($urandom_range(10, 200));
        end
        keys = 16'h0;
        tick(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
